ladybird_serial_mem_bridge: RTL and testbench

Command responder on the device side of the UART link. It consumes the byte stream delivered by `ladybird_serial_interface` (O_BYTES=1), decodes host read and write commands, and issues single-word memory requests. It returns acknowledge or read-data bytes to the same interface for transmission back to the host.

---
 rtl/ladybird_serial_mem_bridge.sv | 273 +++++++++++++++++++++++++++
 tb/tb_ladybird_serial_mem_bridge.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_serial_mem_bridge.sv
// ladybird_serial_mem_bridge
// Device-side command responder for the UART link. Decodes 'W' (0x57) and
// 'R' (0x52) commands from the serial byte stream, issues one memory request
// per command and streams back an ACK (0x06), the read data, or a NAK (0x15).
// All multi-byte fields are little-endian.
//
// Optional feature: define LADYBIRD_MEM_BRIDGE_TIMEOUT_EN to abort a command
// whose ADDR/DATA bytes stall for TIMEOUT clk cycles (answered with NAK).
//
// Handshakes: every channel (in_*, out_*, mem_*) transfers on a cycle where
// valid && ready are both high at the rising clk edge; a producer holds its
// valid and payload unchanged until that edge. mem_rvalid is a one-cycle
// pulse with no ready.
module ladybird_serial_mem_bridge #(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter logic [31:0] TIMEOUT = 32'd10_000_000
) (
  input  logic              clk,
  input  logic              anrst,
  input  logic              nrst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_valid,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [2:0]        state_dbg
);

  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int DATA_BYTES = DATA_W / 8;
  localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CW         = $clog2(MAX_BYTES) + 1;

  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BYTES - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BYTES - 1);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_REQ  = 3'd3,
    S_WAIT = 3'd4,
    S_RESP = 3'd5,
    S_NAK  = 3'd6
  } state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n, cnt_inc;
  logic                op_write, op_write_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   wdata_n;
  logic                we_n, mvalid_n, ovalid_n;
  logic [7:0]          odata_n;
  logic [DATA_W-1:0]   rbuf, rbuf_n;
  logic                timeout_hit;

  assign state_dbg = state;
  assign cnt_inc   = cnt + CW'(1);

`ifdef LADYBIRD_MEM_BRIDGE_TIMEOUT_EN
  logic [31:0] tcnt;

  // Idle-cycle counter: runs only while a command is half received.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      tcnt <= '0;
    end else if (!nrst) begin
      tcnt <= '0;
    end else if ((state == S_ADDR || state == S_DATA) && !in_valid) begin
      tcnt <= tcnt + 32'd1;
    end else begin
      tcnt <= '0;
    end
  end

  assign timeout_hit = (tcnt >= TIMEOUT - 32'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  // Byte acceptance depends on state only, so hosts can never see a combinational loop.
  always_comb begin
    in_ready = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA);
  end

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    op_write_n = op_write;
    addr_n     = mem_addr;
    wdata_n    = mem_wdata;
    we_n       = mem_we;
    mvalid_n   = mem_valid;
    ovalid_n   = out_valid;
    odata_n    = out_data;
    rbuf_n     = rbuf;

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          cnt_n = '0;
          if (in_data == CMD_WRITE) begin
            op_write_n = 1'b1;
            state_n    = S_ADDR;
          end else if (in_data == CMD_READ) begin
            op_write_n = 1'b0;
            state_n    = S_ADDR;
          end else begin
            ovalid_n = 1'b1;
            odata_n  = RSP_NAK;
            state_n  = S_NAK;
          end
        end
      end

      S_ADDR: begin
        if (in_valid) begin
          for (int i = 0; i < ADDR_BYTES; i++) begin
            if (cnt == CW'(i)) addr_n[i*8 +: 8] = in_data;
          end
          if (cnt == ADDR_LAST) begin
            cnt_n = '0;
            if (op_write) begin
              state_n = S_DATA;
            end else begin
              we_n     = 1'b0;
              mvalid_n = 1'b1;
              state_n  = S_REQ;
            end
          end else begin
            cnt_n = cnt_inc;
          end
        end else if (timeout_hit) begin
          cnt_n    = '0;
          ovalid_n = 1'b1;
          odata_n  = RSP_NAK;
          state_n  = S_NAK;
        end
      end

      S_DATA: begin
        if (in_valid) begin
          for (int i = 0; i < DATA_BYTES; i++) begin
            if (cnt == CW'(i)) wdata_n[i*8 +: 8] = in_data;
          end
          if (cnt == DATA_LAST) begin
            cnt_n    = '0;
            we_n     = 1'b1;
            mvalid_n = 1'b1;
            state_n  = S_REQ;
          end else begin
            cnt_n = cnt_inc;
          end
        end else if (timeout_hit) begin
          cnt_n    = '0;
          ovalid_n = 1'b1;
          odata_n  = RSP_NAK;
          state_n  = S_NAK;
        end
      end

      S_REQ: begin
        if (mem_ready) begin
          mvalid_n = 1'b0;
          cnt_n    = '0;
          if (op_write) begin
            ovalid_n = 1'b1;
            odata_n  = RSP_ACK;
            state_n  = S_RESP;
          end else begin
            state_n = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (mem_rvalid) begin
          rbuf_n   = mem_rdata;
          ovalid_n = 1'b1;
          odata_n  = mem_rdata[7:0];
          cnt_n    = '0;
          state_n  = S_RESP;
        end
      end

      S_RESP: begin
        if (out_ready) begin
          if (op_write || cnt == DATA_LAST) begin
            ovalid_n = 1'b0;
            cnt_n    = '0;
            state_n  = S_IDLE;
          end else begin
            cnt_n = cnt_inc;
            for (int i = 0; i < DATA_BYTES; i++) begin
              if (cnt_inc == CW'(i)) odata_n = rbuf[i*8 +: 8];
            end
          end
        end
      end

      S_NAK: begin
        if (out_ready) begin
          ovalid_n = 1'b0;
          cnt_n    = '0;
          state_n  = S_IDLE;
        end
      end

      default: begin
        ovalid_n = 1'b0;
        mvalid_n = 1'b0;
        cnt_n    = '0;
        state_n  = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; both resets discard any partial command.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_write  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_valid <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      rbuf      <= '0;
    end else if (!nrst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_write  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_valid <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      rbuf      <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      op_write  <= op_write_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_we    <= we_n;
      mem_valid <= mvalid_n;
      out_valid <= ovalid_n;
      out_data  <= odata_n;
      rbuf      <= rbuf_n;
    end
  end

endmodule

// File: tb/tb_ladybird_serial_mem_bridge.sv
// Testbench for ladybird_serial_mem_bridge: randomized command stream against
// a memory-map reference model; expected bytes and requests are queued at
// issue time and a monitor pops them as the DUT presents them.
module tb_ladybird_serial_mem_bridge;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          anrst, nrst;
  logic [7:0]    in_data;
  logic          in_valid, in_ready;
  logic [7:0]    out_data;
  logic          out_valid, out_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we, mem_valid, mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  ladybird_serial_mem_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(32'd100)) dut (
    .clk(clk), .anrst(anrst), .nrst(nrst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [7:0]  exp_q[$];            // response bytes in order
  logic [64:0] exp_mem_q[$];        // {we, addr, wdata}
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];
  bit bp_mem = 1'b0;
  bit bp_out = 1'b0;
  int rd_delay_cfg = -1;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL in_ready_wait: got in_ready=0 for %0d cycles required 1", n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    exp_mem_q.push_back({1'b1, a, d});
    exp_q.push_back(8'h06);
    ref_mem[a] = d;
    send_byte(8'h57);
    send_word(a);
    send_word(d);
  endtask

  task automatic expect_read(input logic [31:0] a);
    logic [31:0] d;
    d = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    exp_mem_q.push_back({1'b0, a, 32'h0});
    for (int i = 0; i < 4; i++) exp_q.push_back(d[i*8 +: 8]);
  endtask

  task automatic do_read(input logic [31:0] a);
    expect_read(a);
    send_byte(8'h52);
    send_word(a);
  endtask

  task automatic do_bad(input logic [7:0] b);
    exp_q.push_back(8'h15);
    send_byte(b);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_mem_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_out_left"}, exp_q.size(), 0);
    check({tag, "_mem_left"}, exp_mem_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data, 0);
    check({tag, "_mem_valid"}, mem_valid, 0);
    check({tag, "_mem_we"},    mem_we, 0);
    check({tag, "_mem_addr"},  mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // ---------------- memory / sink responder ----------------
  initial begin
    bit          hs, hs_we, rd_pend;
    logic [31:0] hs_addr, hs_wdata, rd_data;
    int          rd_cnt, hold_cnt;
    mem_ready  = 1'b0;
    out_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    rd_pend    = 1'b0;
    rd_cnt     = 0;
    hold_cnt   = 0;
    rd_data    = '0;
    forever begin
      @(negedge clk);
      hs       = mem_valid && mem_ready && anrst && nrst;
      hs_we    = mem_we;
      hs_addr  = mem_addr;
      hs_wdata = mem_wdata;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      if (hs) begin
        if (hs_we) begin
          dev_mem[hs_addr] = hs_wdata;
        end else begin
          rd_pend = 1'b1;
          rd_cnt  = (rd_delay_cfg >= 0) ? rd_delay_cfg : $urandom_range(0, 4);
          rd_data = dev_mem.exists(hs_addr) ? dev_mem[hs_addr] : init_word(hs_addr);
        end
      end
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd_data;
          rd_pend    = 1'b0;
        end else begin
          rd_cnt--;
        end
      end else if (!hs && $urandom_range(0, 7) == 0) begin
        mem_rvalid = 1'b1;            // stray pulse the bridge must ignore
        mem_rdata  = $urandom;
      end
      if (bp_mem) begin
        hold_cnt  = mem_valid ? hold_cnt + 1 : 0;
        mem_ready = (hold_cnt > 20);
      end else begin
        mem_ready = ($urandom_range(0, 3) != 0);
      end
      out_ready = bp_out ? ~out_ready : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit          hold_o, hold_m;
    logic [7:0]  held_d, e;
    logic [31:0] held_a, held_w;
    logic        held_we;
    logic [64:0] em;
    hold_o = 1'b0;
    hold_m = 1'b0;
    forever begin
      @(negedge clk);
      if (!anrst || !nrst) begin
        hold_o = 1'b0;
        hold_m = 1'b0;
        continue;
      end
      if (hold_o) begin
        check("out_hold_valid", out_valid, 1);
        check("out_hold_data", out_data, held_d);
      end
      if (hold_m) begin
        check("mem_hold_valid", mem_valid, 1);
        check("mem_hold_we", mem_we, held_we);
        check("mem_hold_addr", mem_addr, held_a);
        check("mem_hold_wdata", mem_wdata, held_w);
      end
      if (out_valid || mem_valid) check("in_ready_busy", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got 0x%0h required no byte at %0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_byte", out_data, e);
        end
      end
      if (mem_valid && mem_ready) begin
        if (exp_mem_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_mem: got addr 0x%0h we %0d required no request", mem_addr, mem_we);
        end else begin
          em = exp_mem_q.pop_front();
          check("mem_we", mem_we, em[64]);
          check("mem_addr", mem_addr, em[63:32]);
          if (em[64]) check("mem_wdata", mem_wdata, em[31:0]);
        end
      end
      hold_o  = out_valid && !out_ready;
      held_d  = out_data;
      hold_m  = mem_valid && !mem_ready;
      held_we = mem_we;
      held_a  = mem_addr;
      held_w  = mem_wdata;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    int          k;
    anrst    = 1'b0;
    nrst     = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1 anrst = 1'b1;
    @(negedge clk);

    // directed write and read
    do_write(32'h1234_5678, 32'hDEAD_BEEF);
    wait_drain("write");
    ref_mem[32'h4] = 32'hCAFE_BABE;
    dev_mem[32'h4] = 32'hCAFE_BABE;
    rd_delay_cfg = 1;
    do_read(32'h4);
    wait_drain("read");
    rd_delay_cfg = -1;

    // bad command followed by a normal read
    do_bad(8'h41);
    do_read(32'h1234_5678);
    wait_drain("bad");

    // backpressure on both sides
    bp_mem = 1'b1;
    bp_out = 1'b1;
    do_write(32'h0000_0040, 32'h0BAD_F00D);
    do_read(32'h0000_0040);
    wait_drain("bp");
    bp_mem = 1'b0;
    bp_out = 1'b0;

    // synchronous reset in the middle of a write
    send_byte(8'h57);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(posedge clk);
    #1 nrst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("srst");
    @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    do_write(32'h0000_0080, 32'h1357_9BDF);
    do_read(32'h0000_0080);
    wait_drain("after_srst");

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) == 0) ? $urandom : (32'h100 + 32'($urandom_range(0, 3)) * 4);
      if (k < 4)      do_write(a, $urandom);
      else if (k < 8) do_read(a);
      else begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        do_bad(b);
      end
    end
    wait_drain("random");

    // stall mid-address
`ifdef LADYBIRD_MEM_BRIDGE_TIMEOUT_EN
    exp_q.push_back(8'h15);
`endif
    send_byte(8'h52);
    send_byte(8'h01);
    repeat (101) @(negedge clk);
`ifdef LADYBIRD_MEM_BRIDGE_TIMEOUT_EN
    wait_drain("timeout");
    check("timeout_no_mem", mem_valid, 0);
`else
    check("stall_no_out", out_valid, 0);
    check("stall_no_mem", mem_valid, 0);
    expect_read(32'h0000_0001);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_drain("stall");
`endif

    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
